// File: rtl/layer_pipe_pkg.sv
// layer_pipe_pkg
// Definitions shared by the layer pipe stage 1 back-end and, later, the sprite
// path. This covers header register indices, CTRL bit positions, sequencer FSM
// encoding and the layer descriptor layout.
// Optional build macro used by dependents: LAYER_SEQ_HITCOUNT_EN.
package layer_pipe_pkg;

    localparam int NUM_LAYERS = 32;   // layers scanned per line (power of two)
    localparam int ADDR_W     = 5;    // log2(NUM_LAYERS)
    localparam int DATA_W     = 16;   // header register width
    localparam int Y_W        = 10;   // scanline index width
    localparam int FMT_W      = 4;    // descriptor format field width

    // One header memory per register, all addressed by the same layer index.
    localparam int HDR_CTRL = 0;
    localparam int HDR_X    = 1;
    localparam int HDR_Y    = 2;
    localparam int HDR_H    = 3;

    // CTRL register fields.
    localparam int CTRL_ENABLE  = 15;
    localparam int CTRL_FMT_MSB = 3;
    localparam int CTRL_FMT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } seqState_t;

    // Descriptor handed to pipe stage 2.
    typedef struct packed {
        logic [ADDR_W-1:0] layer;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] row;
        logic [FMT_W-1:0]  format;
    } layerDesc_t;

endpackage

// File: rtl/layer_hit_test.sv
// layer_hit_test
// Purely combinational vertical hit test of one layer/sprite against a line.
// Ports:
//   enable  in   layer enable bit
//   lineY   in   current scanline (LINE_W bits, zero-extended)
//   originY in   layer y origin (unsigned)
//   height  in   layer height in lines
//   hit     out  enable & originY <= lineY < originY + height
//   row     out  lineY - originY, low WIDTH bits
module layer_hit_test
    import layer_pipe_pkg::*;
#(
    parameter int LINE_W = Y_W,
    parameter int WIDTH  = DATA_W
) (
    input  logic              enable,
    input  logic [LINE_W-1:0] lineY,
    input  logic [WIDTH-1:0]  originY,
    input  logic [WIDTH-1:0]  height,
    output logic              hit,
    output logic [WIDTH-1:0]  row
);

    // One extra bit so originY + height never wraps back below the line.
    logic [WIDTH:0] lineExt;
    logic [WIDTH:0] originExt;
    logic [WIDTH:0] bottomExt;

    always_comb begin
        lineExt              = '0;
        lineExt[LINE_W-1:0]  = lineY;
        originExt            = {1'b0, originY};
        bottomExt            = originExt + {1'b0, height};
        hit                  = enable && (lineExt >= originExt) && (lineExt < bottomExt);
        row                  = lineExt[WIDTH-1:0] - originY;
    end

endmodule

// File: rtl/layer_header_sequencer.sv
// layer_header_sequencer
// Pipe stage 1 back-end. On each lineStart walks layer indices 0..NUM_LAYERS-1
// through one shared async-read header address, hit-tests each layer against
// the latched line and emits one descriptor per hit, in ascending layer order,
// over a valid/ready handshake.
// Ports:
//   clk, reset           clock, async active-low reset
//   lineStart, lineY     one-cycle scan request and its scanline
//   hdrReadAddr          layer index to all header memories
//   hdrCtrl/X/Y/H        header data at hdrReadAddr (same cycle)
//   outValid, outReady   descriptor handshake to stage 2
//   outLayer/X/Row/Format descriptor fields
//   busy                 not IDLE
//   lineDone             one-cycle pulse at end of a line
//   hitCount             handshakes this line (only with LAYER_SEQ_HITCOUNT_EN)
// Build macro: LAYER_SEQ_HITCOUNT_EN adds the hitCount output and counter.
module layer_header_sequencer
    import layer_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              lineStart,
    input  logic [Y_W-1:0]    lineY,
    output logic [ADDR_W-1:0] hdrReadAddr,
    input  logic [DATA_W-1:0] hdrCtrl,
    input  logic [DATA_W-1:0] hdrX,
    input  logic [DATA_W-1:0] hdrY,
    input  logic [DATA_W-1:0] hdrH,
    output logic              outValid,
    input  logic              outReady,
    output logic [ADDR_W-1:0] outLayer,
    output logic [DATA_W-1:0] outX,
    output logic [DATA_W-1:0] outRow,
    output logic [FMT_W-1:0]  outFormat,
    output logic              busy,
    output logic              lineDone
`ifdef LAYER_SEQ_HITCOUNT_EN
    ,
    output logic [ADDR_W:0]   hitCount
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LAYERS - 1);

    seqState_t         state, stateNext;
    logic [ADDR_W-1:0] idx, idxNext;
    logic              validReg, validNext;
    logic [Y_W-1:0]    lineReg;
    layerDesc_t        descReg;
    logic              latchLine;
    logic              loadDesc;
    logic              handshake;
    logic              hit;
    logic [DATA_W-1:0] row;
    logic              unusedCtrlBits;

    // Reserved CTRL bits are not interpreted here.
    assign unusedCtrlBits = ^hdrCtrl[CTRL_ENABLE-1:CTRL_FMT_MSB+1];

    // The header memories are read asynchronously, so the data for idx is
    // valid in the same cycle; no pipeline bubble between layers.
    assign hdrReadAddr = idx;
    assign handshake   = validReg && outReady;

    layer_hit_test #(
        .LINE_W (Y_W),
        .WIDTH  (DATA_W)
    ) uHitTest (
        .enable  (hdrCtrl[CTRL_ENABLE]),
        .lineY   (lineReg),
        .originY (hdrY),
        .height  (hdrH),
        .hit     (hit),
        .row     (row)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            validReg <= 1'b0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            validReg <= validNext;
        end
    end

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        validNext = validReg;
        latchLine = 1'b0;
        loadDesc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lineStart) begin
                    latchLine = 1'b1;
                    idxNext   = '0;
                    stateNext = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (hit) begin
                    loadDesc  = 1'b1;
                    validNext = 1'b1;
                    stateNext = ST_EMIT;
                end else if (idx == LAST_IDX) begin
                    stateNext = ST_DONE;
                end else begin
                    idxNext = idx + 1'b1;
                end
            end
            ST_EMIT: begin
                // idx still points at the emitted layer; advance only once
                // stage 2 has taken the descriptor.
                if (handshake) begin
                    validNext = 1'b0;
                    if (idx == LAST_IDX) begin
                        stateNext = ST_DONE;
                    end else begin
                        idxNext   = idx + 1'b1;
                        stateNext = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lineReg <= '0;
            descReg <= '0;
        end else begin
            if (latchLine) begin
                lineReg <= lineY;
            end
            if (loadDesc) begin
                descReg.layer  <= idx;
                descReg.x      <= hdrX;
                descReg.row    <= row;
                descReg.format <= hdrCtrl[CTRL_FMT_MSB:CTRL_FMT_LSB];
            end
        end
    end

`ifdef LAYER_SEQ_HITCOUNT_EN
    // Width ADDR_W+1 holds NUM_LAYERS hits without wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hitCount <= '0;
        end else if (latchLine) begin
            hitCount <= '0;
        end else if (handshake) begin
            hitCount <= hitCount + 1'b1;
        end
    end
`endif

    assign outValid  = validReg;
    assign outLayer  = descReg.layer;
    assign outX      = descReg.x;
    assign outRow    = descReg.row;
    assign outFormat = descReg.format;
    assign busy      = (state != ST_IDLE);
    assign lineDone  = (state == ST_DONE);

endmodule

// File: tb/tb_layer_header_sequencer.sv
// Self-checking bench for layer_header_sequencer: table of single-layer hit
// vectors, hand-written multi-cycle sequences and randomized lines compared
// against a plain-arithmetic model of the header hit rules.
module tb_layer_header_sequencer;
    import layer_pipe_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              lineStart = 1'b0;
    logic [Y_W-1:0]    lineY = '0;
    logic              outReady = 1'b0;
    logic [ADDR_W-1:0] hdrReadAddr;
    logic [DATA_W-1:0] hdrCtrl, hdrX, hdrY, hdrH;
    logic              outValid;
    logic [ADDR_W-1:0] outLayer;
    logic [DATA_W-1:0] outX, outRow;
    logic [FMT_W-1:0]  outFormat;
    logic              busy, lineDone;
`ifdef LAYER_SEQ_HITCOUNT_EN
    logic [ADDR_W:0]   hitCount;
`endif

    logic [DATA_W-1:0] ctrlMem [NUM_LAYERS];
    logic [DATA_W-1:0] xMem    [NUM_LAYERS];
    logic [DATA_W-1:0] yMem    [NUM_LAYERS];
    logic [DATA_W-1:0] hMem    [NUM_LAYERS];

    assign hdrCtrl = ctrlMem[hdrReadAddr];
    assign hdrX    = xMem[hdrReadAddr];
    assign hdrY    = yMem[hdrReadAddr];
    assign hdrH    = hMem[hdrReadAddr];

    layer_header_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .lineStart   (lineStart),
        .lineY       (lineY),
        .hdrReadAddr (hdrReadAddr),
        .hdrCtrl     (hdrCtrl),
        .hdrX        (hdrX),
        .hdrY        (hdrY),
        .hdrH        (hdrH),
        .outValid    (outValid),
        .outReady    (outReady),
        .outLayer    (outLayer),
        .outX        (outX),
        .outRow      (outRow),
        .outFormat   (outFormat),
        .busy        (busy),
        .lineDone    (lineDone)
`ifdef LAYER_SEQ_HITCOUNT_EN
        ,
        .hitCount    (hitCount)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [40:0] expQ[$];
    logic [40:0] gotQ[$];

    typedef struct {
        int          layer;
        logic [15:0] ctrl, x, y, h;
        logic [9:0]  line;
        bit          expHit;
        logic [15:0] expRow;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearHdr();
        for (int l = 0; l < NUM_LAYERS; l++) begin
            ctrlMem[l] = '0; xMem[l] = '0; yMem[l] = '0; hMem[l] = '0;
        end
    endtask

    task automatic setLayer(input int l, input logic [15:0] c, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] h);
        ctrlMem[l] = c; xMem[l] = x; yMem[l] = y; hMem[l] = h;
    endtask

    function automatic logic [40:0] mkDesc(input int l, input logic [15:0] x,
                                           input logic [15:0] row, input logic [3:0] fmt);
        logic [4:0] lb;
        lb = l[4:0];
        return {lb, x, row, fmt};
    endfunction

    // Reference: every enabled layer whose [y, y+h) range covers the line,
    // ascending layer order, unbounded integer arithmetic.
    task automatic modelLine(input int line);
        expQ.delete();
        for (int l = 0; l < NUM_LAYERS; l++) begin
            int y;
            int h;
            y = int'(yMem[l]);
            h = int'(hMem[l]);
            if (ctrlMem[l][15] && line >= y && line < y + h)
                expQ.push_back(mkDesc(l, xMem[l], 16'(line - y), ctrlMem[l][3:0]));
        end
    endtask

    // mode 0: always ready, 1: ready after 5 stalled valid cycles, 2: random
    task automatic runLine(input logic [9:0] ln, input int mode, output int doneAt);
        int c;
        int vcnt;
        logic prevStall;
        logic [40:0] prevD;
        logic [40:0] d;
        logic rdy;
        gotQ.delete();
        doneAt = -1;
        vcnt = 0;
        prevStall = 1'b0;
        prevD = '0;
        @(negedge clk);
        lineY = ln; lineStart = 1'b1; outReady = 1'b0;
        c = 0;
        while (c < 600) begin
            @(negedge clk);
            lineStart = 1'b0;
            c++;
            d = {outLayer, outX, outRow, outFormat};
            if (prevStall) begin
                check("stall_valid", outValid, 1);
                check("stall_fields", d, prevD);
            end
            if (lineDone) begin
                doneAt = c;
                break;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (vcnt >= 5);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            outReady = rdy;
            if (outValid) vcnt++;
            if (outValid && rdy) begin
                gotQ.push_back(d);
                vcnt = 0;
            end
            prevStall = outValid && !rdy;
            prevD = d;
        end
        outReady = 1'b0;
        if (doneAt < 0) check("lineDone_timeout", 0, 1);
    endtask

    task automatic compareQ(input string tag);
        check({tag, "_count"}, 64'(gotQ.size()), 64'(expQ.size()));
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
            check({tag, "_desc"}, gotQ[i], expQ[i]);
    endtask

    initial begin
        vec_t vecs[10];
        int doneAt;
        int cnt;
        int firstDone;
        int pulses;
        logic sawValid;
        logic sawDone;

        vecs[0] = '{3,  16'h8005, 16'd40,  16'd90,    16'd20,   10'd100,  1'b1, 16'd10};
        vecs[1] = '{5,  16'h8001, 16'd7,   16'd100,   16'd1,    10'd100,  1'b1, 16'd0};
        vecs[2] = '{5,  16'h8001, 16'd7,   16'd100,   16'd1,    10'd99,   1'b0, 16'd0};
        vecs[3] = '{5,  16'h8001, 16'd7,   16'd100,   16'd1,    10'd101,  1'b0, 16'd0};
        vecs[4] = '{9,  16'h8002, 16'd0,   16'hFFF0,  16'h0020, 10'd5,    1'b0, 16'd0};
        vecs[5] = '{2,  16'h800F, 16'd1,   16'd0,     16'd0,    10'd0,    1'b0, 16'd0};
        vecs[6] = '{0,  16'h8003, 16'd123, 16'd0,     16'd1024, 10'd1023, 1'b1, 16'd1023};
        vecs[7] = '{31, 16'h8004, 16'd999, 16'd500,   16'd10,   10'd509,  1'b1, 16'd9};
        vecs[8] = '{31, 16'h0004, 16'd999, 16'd500,   16'd10,   10'd509,  1'b0, 16'd0};
        vecs[9] = '{12, 16'h8006, 16'd5,   16'd1023,  16'd1,    10'd1023, 1'b1, 16'd0};

        clearHdr();
        #1 reset = 1'b0;

        // Reset held low while lineStart pulses.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lineStart = (i % 2 == 0);
            lineY = 10'd100;
            #1;
            check("reset_outputs", {hdrReadAddr, outValid, outLayer, outX, outRow, outFormat, busy, lineDone}, 0);
        end
        @(negedge clk);
        lineStart = 1'b0;
        reset = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sawValid = sawValid | outValid | busy;
        end
        check("post_reset_idle", sawValid, 0);

        // Single-layer table.
        foreach (vecs[i]) begin
            clearHdr();
            setLayer(vecs[i].layer, vecs[i].ctrl, vecs[i].x, vecs[i].y, vecs[i].h);
            expQ.delete();
            if (vecs[i].expHit)
                expQ.push_back(mkDesc(vecs[i].layer, vecs[i].x, vecs[i].expRow, vecs[i].ctrl[3:0]));
            runLine(vecs[i].line, 0, doneAt);
            compareQ($sformatf("vec%0d", i));
            check($sformatf("vec%0d_doneAt", i), 64'(doneAt), 64'(33 + int'(vecs[i].expHit)));
        end

        // All disabled: lineDone exactly 33 cycles after lineStart, single pulse.
        clearHdr();
        expQ.delete();
        runLine(10'd100, 0, doneAt);
        compareQ("nohit");
        check("nohit_doneAt", 64'(doneAt), 33);
        @(negedge clk);
        check("nohit_after", {lineDone, busy}, 0);

        // Layers 0, 7, 31 with 5 stall cycles each.
        clearHdr();
        setLayer(0,  16'h8001, 16'd10, 16'd50, 16'd100);
        setLayer(7,  16'h8002, 16'd20, 16'd50, 16'd100);
        setLayer(31, 16'h8003, 16'd30, 16'd50, 16'd100);
        expQ.delete();
        expQ.push_back(mkDesc(0,  16'd10, 16'd50, 4'd1));
        expQ.push_back(mkDesc(7,  16'd20, 16'd50, 4'd2));
        expQ.push_back(mkDesc(31, 16'd30, 16'd50, 4'd3));
        runLine(10'd100, 1, doneAt);
        compareQ("stall3");
        check("stall3_doneAt", 64'(doneAt), 51);
`ifdef LAYER_SEQ_HITCOUNT_EN
        check("stall3_hitCount", 64'(hitCount), 3);
`endif

        // Async reset while a descriptor is stalled.
        @(negedge clk);
        lineY = 10'd100; lineStart = 1'b1; outReady = 1'b0;
        cnt = 0;
        @(negedge clk);
        lineStart = 1'b0;
        while (!outValid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_emit_reached", outValid, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_emit_clear", {outValid, busy, lineDone}, 0);
`ifdef LAYER_SEQ_HITCOUNT_EN
        check("rst_emit_hitCount", 64'(hitCount), 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        outReady = 1'b1;
        sawValid = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            sawValid = sawValid | outValid;
            sawDone = sawDone | lineDone;
        end
        check("rst_emit_novalid", sawValid, 0);
        check("rst_emit_nodone", sawDone, 0);
        outReady = 1'b0;

        // lineStart re-issued mid-scan with a different line must be ignored.
        clearHdr();
        setLayer(20, 16'h8007, 16'd77, 16'd100, 16'd1);
        gotQ.delete();
        firstDone = -1;
        pulses = 0;
        @(negedge clk);
        lineY = 10'd100; lineStart = 1'b1; outReady = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            lineStart = (c == 10);
            if (c == 10) lineY = 10'd200;
            if (lineDone) begin
                pulses++;
                if (firstDone < 0) firstDone = c;
            end
            if (outValid && outReady) gotQ.push_back({outLayer, outX, outRow, outFormat});
        end
        lineStart = 1'b0;
        outReady = 1'b0;
        expQ.delete();
        expQ.push_back(mkDesc(20, 16'd77, 16'd0, 4'd7));
        compareQ("restart");
        check("restart_doneAt", 64'(firstDone), 34);
        check("restart_pulses", 64'(pulses), 1);

        // Randomized headers, lines and back-pressure.
        for (int t = 0; t < 30; t++) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
                ctrlMem[l] = 16'($urandom);
                ctrlMem[l][15] = ($urandom_range(0, 2) != 0);
                xMem[l] = 16'($urandom);
                yMem[l] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1100));
                hMem[l] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
            end
            lineY = 10'($urandom);
            modelLine(int'(lineY));
            runLine(lineY, 2, doneAt);
            compareQ($sformatf("rand%0d", t));
`ifdef LAYER_SEQ_HITCOUNT_EN
            check("rand_hitCount", 64'(hitCount), 64'(expQ.size()));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/layer_header_sequencer.md
Name: layer_header_sequencer

Overview:
Pipe stage 1 back-end. Sits directly downstream of the per-register layer header memories (one memory per header register, each holding that register for all 32 layers).
- On each scanline start, walks layer indices 0..NUM_LAYERS-1 through one shared read address.
- Hit-tests each enabled layer against the current line.
- Emits one descriptor per hit to pipe stage 2 over a valid/ready handshake, in ascending layer order. Layer 0 is emitted first.

Parameters:
NUM_LAYERS, 32, layers scanned per line (power of two)
ADDR_W, 5, layer index width, log2(NUM_LAYERS)
DATA_W, 16, header register width
Y_W, 10, scanline index width

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low master reset
lineStart  in  1  one-cycle pulse: begin scan for lineY
lineY  in  Y_W  scanline index, sampled when lineStart=1
hdrReadAddr  out  ADDR_W  layer index driven to all header memories (async read)
hdrCtrl  in  DATA_W  reg0 data at hdrReadAddr: bit15 enable, bits3:0 format
hdrX  in  DATA_W  reg1 data: layer x origin
hdrY  in  DATA_W  reg2 data: layer y origin (unsigned)
hdrH  in  DATA_W  reg3 data: layer height in lines
outValid  out  1  descriptor valid
outReady  in  1  stage 2 accepts descriptor
outLayer  out  ADDR_W  layer index of descriptor
outX  out  DATA_W  copy of hdrX
outRow  out  DATA_W  lineY - hdrY (row within layer)
outFormat  out  4  hdrCtrl[3:0]
busy  out  1  high in any state other than IDLE
lineDone  out  1  one-cycle pulse when scan of a line completes

Behaviour:
Reset:
- Async, active-low. Forces state=IDLE, idx=0, and all outputs 0: hdrReadAddr, outValid, outLayer, outX, outRow, outFormat, busy, lineDone.
- Reset mid-scan abandons the line. No lineDone is issued for it.

Address and hit test:
- hdrReadAddr = idx at all times. Header data is sampled in the same cycle (memories read asynchronously).
- hit = hdrCtrl[15] & ({1'b0,lineY} >= hdrY) & ({1'b0,lineY} < hdrY + hdrH).
- Sum and compare use DATA_W+1 bits, so y+h overflow is not truncated.
- hdrH=0 never hits.

FSM states IDLE, SCAN, EMIT, DONE:
- IDLE: on lineStart, latch lineY into lineReg, set idx=0, go to SCAN. lineStart in any other state is ignored.
- SCAN (one layer per cycle):
  - If hit: register outLayer=idx, outX, outRow=lineReg-hdrY (low DATA_W bits), outFormat; set outValid=1; go to EMIT.
  - Else if idx==NUM_LAYERS-1: go to DONE.
  - Else: idx+1, stay in SCAN.
- EMIT:
  - Hold all out* stable while outValid & !outReady.
  - On outValid & outReady: clear outValid. If idx==NUM_LAYERS-1 go to DONE, else idx+1 and go to SCAN.
- DONE: lineDone=1 for exactly this cycle, then IDLE. Earliest next lineStart is accepted in IDLE.

Timing and boundaries:
- Latency: first descriptor valid 1 cycle after the SCAN cycle that finds the hit.
- Throughput: 1 descriptor per 2 cycles max.
- No-hit line: lineDone exactly NUM_LAYERS+1 cycles after lineStart.
- Header writes landing mid-scan are seen only by layers not yet visited. No snapshot is taken.
- outReady is ignored when outValid=0.

Optional Feature:
LAYER_SEQ_HITCOUNT_EN
- Defined: adds output hitCount [ADDR_W:0].
  - Cleared when lineStart is accepted.
  - Incremented on each outValid&outReady handshake.
  - Valid and stable from the lineDone cycle until the next accepted lineStart.
  - Reset value 0.
  - 32 hits gives 6'd32 (no wrap).
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package layer_pipe_pkg holds:
  - header register indices (CTRL=0, X=1, Y=2, H=3)
  - CTRL bit positions (ENABLE=15, FORMAT=3:0)
  - FSM state encoding
  - descriptor field widths
- Sub-module layer_hit_test: purely combinational, holding the enable/range compare and row subtract. Reused later by the sprite path.

Test Plan:
- Reset held low while lineStart pulses -> all outputs 0, busy=0. After release, no descriptor appears.
- All layers disabled, lineStart with lineY=100 -> no outValid. lineDone pulses at cycle 33 after lineStart.
- Layer 3: ctrl=16'h8005, x=40, y=90, h=20; lineY=100, outReady=1 -> one descriptor: outLayer=3, outX=40, outRow=10, outFormat=5.
- Layers 0, 7, 31 enabled and hitting, outReady low for 5 cycles on each -> descriptors in order 0, 7, 31; fields held stable while stalled; lineDone only after layer 31 is accepted.
- Boundary: layer y=100, h=1 hits at lineY=100 only, not 99 or 101. Layer y=16'hFFF0, h=16'h20 at lineY=5 gives no hit (no wraparound). h=0 never hits.
- Async reset asserted mid-EMIT; lineStart re-issued mid-scan -> reset gives immediate IDLE, outValid=0, no lineDone; extra lineStart while busy is ignored. With LAYER_SEQ_HITCOUNT_EN, hitCount=3 after the three-hit line.
